// File: rtl/fsm_rr_arbiter.sv
// Four-requester round-robin arbiter built as a Moore FSM (IDLE/GRANT/RELEASE).
// Define FSM_ARB_TIMEOUT_EN to add a watchdog that revokes a tenure after HOLD_MAX cycles.
module fsm_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] p_state
);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_GRANT   = 2'b01;
    localparam logic [1:0] S_RELEASE = 2'b10;

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       owner_req;
    logic       expire;

    assign p_state   = state;
    assign owner_req = req[owner];

    // Scan from the farthest offset down so the lowest offset from ptr wins.
    // NOTE: winner gets a default before the loop so no latch is inferred.
    always_comb begin
        logic [1:0] cand;
        winner = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) winner = cand;
        end
    end

`ifdef FSM_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;

    // The count is of GRANT cycles already completed; the edge ending cycle HOLD_MAX expires.
    assign expire = (state == S_GRANT) && (hold_cnt >= HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == S_GRANT) begin
                hold_cnt <= hold_cnt + 8'd1;
                // A voluntary drop on the expiry cycle is a normal release.
                if (owner_req && expire) timeout <= 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // NOTE: all state registers use non-blocking assignment so every branch
    // reads the pre-edge values of state, owner and ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            gnt   <= 4'b0000;
            owner <= 2'b00;
            ptr   <= 2'b00;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state <= S_GRANT;
                        gnt   <= 4'b0001 << winner;
                        owner <= winner;
                        busy  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!owner_req || expire) begin
                        state <= S_RELEASE;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                    ptr   <= owner + 2'd1;
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter: expected grants are queued as stimulus is
// applied and a monitor pops and compares them as each new grant appears.
module tb_fsm_rr_arbiter;

    typedef struct {
        logic [3:0] gnt;
        int         gap;   // required idle cycles before this grant, -1 = don't care
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [1:0] p_state;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    fsm_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout),
        .p_state (p_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Monitor: a zero-to-nonzero transition of gnt is a new grant.
    initial begin
        logic [3:0] prev_gnt;
        int         gap;
        exp_t       e;
        prev_gnt = 4'b0000;
        gap      = 0;
        forever begin
            @(negedge clk);
            if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", 32'(gnt), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("grant_value", 32'(gnt), 32'(e.gnt));
                    if (e.gap >= 0) check("grant_gap", 32'(gap), 32'(e.gap));
                end
            end
            if (gnt === 4'b0000) gap++;
            else gap = 0;
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic [3:0] g;
        rst = 1'b1;
        req = 4'b0000;

        // Reset state
        cyc();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_state", 32'(p_state), 32'h0);
        rst = 1'b0;
        cyc();
        check("idle_no_req_state", 32'(p_state), 32'h0);
        check("idle_no_req_gnt", 32'(gnt), 32'h0);

        // Single requester 2, five-cycle tenure
        req = 4'b0100;
        sb.push_back('{4'b0100, -1});
        cyc();
        check("r2_gnt", 32'(gnt), 32'h4);
        check("r2_owner", 32'(owner), 32'h2);
        check("r2_busy", 32'(busy), 32'h1);
        check("r2_state", 32'(p_state), 32'h1);
        repeat (4) begin
            cyc();
            check("r2_hold", 32'(gnt), 32'h4);
        end
        req = 4'b0000;
        cyc();
        check("r2_rel_state", 32'(p_state), 32'h2);
        check("r2_rel_gnt", 32'(gnt), 32'h0);
        check("r2_rel_busy", 32'(busy), 32'h0);
        check("r2_rel_owner", 32'(owner), 32'h2);
        cyc();
        check("r2_idle_state", 32'(p_state), 32'h0);
        check("r2_idle_owner", 32'(owner), 32'h2);

        // ptr is now 3: 1001 picks 3, then wraps to 0
        req = 4'b1001;
        sb.push_back('{4'b1000, -1});
        cyc();
        check("wrap_first_gnt", 32'(gnt), 32'h8);
        check("wrap_first_owner", 32'(owner), 32'h3);
        cyc();
        req = 4'b0001;
        sb.push_back('{4'b0001, 2});
        cyc();
        check("wrap_rel_state", 32'(p_state), 32'h2);
        cyc();
        check("wrap_idle_state", 32'(p_state), 32'h0);
        check("wrap_idle_gnt", 32'(gnt), 32'h0);
        cyc();
        check("wrap_second_gnt", 32'(gnt), 32'h1);
        check("wrap_second_owner", 32'(owner), 32'h0);
        req = 4'b0000;
        cyc();
        cyc();

        // Round-robin rotation with all requesters active
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sb.push_back('{4'b0001, -1});
        sb.push_back('{4'b0010, 2});
        sb.push_back('{4'b0100, 2});
        sb.push_back('{4'b1000, 2});
        sb.push_back('{4'b0001, 2});
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            cnt = 0;
            while (gnt === 4'b0000 && cnt < 20) begin
                cyc();
                cnt++;
            end
            if (cnt >= 20) check("rr_grant_wait", 32'(cnt), 32'h0);
            g = gnt;
            cyc();
            cyc();
            req = 4'b1111 & ~g;
            cyc();
            check("rr_release_state", 32'(p_state), 32'h2);
            req = (t == 4) ? 4'b0000 : 4'b1111;
        end
        cyc();

        // Asynchronous reset in the middle of a tenure
        req = 4'b0001;
        sb.push_back('{4'b0001, -1});
        cyc();
        check("pre_rst_gnt", 32'(gnt), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_state", 32'(p_state), 32'h0);
        cyc();
        rst = 1'b0;
        req = 4'b0110;
        sb.push_back('{4'b0010, -1});
        cyc();
        check("post_rst_gnt", 32'(gnt), 32'h2);
        check("post_rst_owner", 32'(owner), 32'h1);
        req = 4'b0000;
        cyc();
        cyc();

`ifdef FSM_ARB_TIMEOUT_EN
        // Watchdog with HOLD_MAX = 4
        req = 4'b0001;
        sb.push_back('{4'b0001, -1});
        sb.push_back('{4'b0001, 2});
        cyc();
        cnt = 0;
        while (gnt === 4'b0001 && cnt < 20) begin
            cnt++;
            cyc();
        end
        check("to_hold_cycles", 32'(cnt), 32'h4);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_rel_state", 32'(p_state), 32'h2);
        cyc();
        check("to_pulse_end", 32'(timeout), 32'h0);
        check("to_idle_state", 32'(p_state), 32'h0);
        cyc();
        check("to_regrant", 32'(gnt), 32'h1);
        req = 4'b0000;
        cyc();
        cyc();
`else
        // Unbounded tenure without the watchdog
        req = 4'b0001;
        sb.push_back('{4'b0001, -1});
        cyc();
        begin
            int bad_g;
            int bad_t;
            bad_g = 0;
            bad_t = 0;
            for (int i = 0; i < 300; i++) begin
                if (gnt !== 4'b0001) bad_g++;
                if (timeout !== 1'b0) bad_t++;
                cyc();
            end
            check("long_hold_gnt_errs", 32'(bad_g), 32'h0);
            check("long_hold_timeout_errs", 32'(bad_t), 32'h0);
        end
        req = 4'b0000;
        cyc();
        cyc();
`endif

        check("scoreboard_left", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
